// File: rtl/struct_stream_deser_pkg.sv
// Shared stream types for the link deserializers: per-struct metadata,
// link width and the deserializer state encoding.
package struct_stream_deser_pkg;

    localparam int LINK_WIDTH = 8;

    // Single metadata record shared by triangle and pixel streams.
    typedef struct packed {
        logic last;
    } stream_metadata_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } deser_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/struct_stream_deser_skid.sv
// Output holding register with valid/ready handshake; a load may only be
// issued while the register is empty or being drained in the same cycle.
module struct_stream_deser_skid
    import struct_stream_deser_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  stream_metadata_t load_meta,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    stream_metadata_t meta_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            meta_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            meta_reg  <= load_meta;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_last  = meta_reg.last;

endmodule

// File: rtl/struct_stream_deser.sv
// Packs IN_WIDTH beats into one OUT_WIDTH struct word with last flag and
// truncation detection. Optional counters: define STRUCT_DESER_STATS_EN.
module struct_stream_deser
    import struct_stream_deser_pkg::*;
#(
    parameter int IN_WIDTH  = LINK_WIDTH,
    parameter int OUT_WIDTH = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 err_trunc
`ifdef STRUCT_DESER_STATS_EN
    ,
    output logic [31:0]          stat_structs,
    output logic [15:0]          stat_trunc
`endif
);

    localparam int BEATS = ceil_div(OUT_WIDTH, IN_WIDTH);
    localparam int PAD   = BEATS * IN_WIDTH - OUT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    deser_state_e     state_reg, state_next;
    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic             err_trunc_reg;
    logic             final_beat;
    logic             beat_acc;
    logic             final_acc;
    logic             trunc_acc;
    logic [OUT_WIDTH-1:0] asm_word;
    stream_metadata_t load_meta;

    assign final_beat = (beat_cnt_reg == CNT_W'(BEATS - 1));
    // Only the closing beat can stall; earlier beats land in the slot registers.
    assign in_ready   = !final_beat || !out_valid || out_ready;
    assign beat_acc   = in_valid && in_ready;
    assign final_acc  = beat_acc && final_beat;
    assign trunc_acc  = beat_acc && in_last && !final_beat;
    assign load_meta  = '{last: in_last};

    // The final beat bypasses storage so the struct appears one cycle after it.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            if (gi == BEATS - 1) begin : g_final
                localparam int FW   = IN_WIDTH - PAD;
                localparam int FLO  = MSB_FIRST ? 0 : (BEATS - 1) * IN_WIDTH;
                localparam int FSRC = MSB_FIRST ? PAD : 0;
                assign asm_word[FLO +: FW] = in_data[FSRC +: FW];
            end else begin : g_store
                localparam int LO = MSB_FIRST ? (BEATS - 1 - gi) * IN_WIDTH - PAD
                                              : gi * IN_WIDTH;
                logic [IN_WIDTH-1:0] slot_reg;
                always_ff @(posedge clk) begin
                    if (!rstn) begin
                        slot_reg <= '0;
                    end else if (beat_acc && beat_cnt_reg == CNT_W'(gi)) begin
                        slot_reg <= in_data;
                    end
                end
                assign asm_word[LO +: IN_WIDTH] = slot_reg;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= COLLECT;
            beat_cnt_reg  <= '0;
            err_trunc_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            err_trunc_reg <= trunc_acc;
        end
    end

    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        if (final_acc || trunc_acc) begin
            beat_cnt_next = '0;
        end else if (beat_acc) begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end
        case (state_reg)
            COLLECT: begin
                if ((final_acc || out_valid) && !out_ready) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    struct_stream_deser_skid #(
        .WIDTH (OUT_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .load      (final_acc),
        .load_data (asm_word),
        .load_meta (load_meta),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    assign err_trunc = err_trunc_reg;

`ifdef STRUCT_DESER_STATS_EN
    logic [31:0] stat_structs_reg;
    logic [15:0] stat_trunc_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_structs_reg <= '0;
            stat_trunc_reg   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                stat_structs_reg <= stat_structs_reg + 32'd1;
            end
            if (err_trunc_reg) begin
                stat_trunc_reg <= stat_trunc_reg + 16'd1;
            end
        end
    end

    assign stat_structs = stat_structs_reg;
    assign stat_trunc   = stat_trunc_reg;
`endif

endmodule

// File: tb/tb_struct_stream_deser.sv
// Directed bench: LSB-first and MSB-first 8->20 bit deserializers share one
// stimulus stream; expected words are hand-computed constants.
module tb_struct_stream_deser;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_l, out_valid_l, out_last_l, err_trunc_l;
    logic [19:0] out_data_l;
    logic        in_ready_m, out_valid_m, out_last_m, err_trunc_m;
    logic [19:0] out_data_m;
`ifdef STRUCT_DESER_STATS_EN
    logic [31:0] stat_structs_l, stat_structs_m;
    logic [15:0] stat_trunc_l, stat_trunc_m;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    struct_stream_deser #(.IN_WIDTH(8), .OUT_WIDTH(20), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_l),
        .out_ready (out_ready),
        .out_data  (out_data_l),
        .out_last  (out_last_l),
        .err_trunc (err_trunc_l)
`ifdef STRUCT_DESER_STATS_EN
        ,
        .stat_structs (stat_structs_l),
        .stat_trunc   (stat_trunc_l)
`endif
    );

    struct_stream_deser #(.IN_WIDTH(8), .OUT_WIDTH(20), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_m),
        .out_ready (out_ready),
        .out_data  (out_data_m),
        .out_last  (out_last_m),
        .err_trunc (err_trunc_m)
`ifdef STRUCT_DESER_STATS_EN
        ,
        .stat_structs (stat_structs_m),
        .stat_trunc   (stat_trunc_m)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-18s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
    endtask

    logic [19:0] thr_l [3] = '{20'h32221, 20'h62524, 20'h92827};
    logic [19:0] thr_m [3] = '{20'h21222, 20'h24252, 20'h27282};

    initial begin
        rstn = 1'b0;
        out_ready = 1'b0;
        idle();
        tick();
        tick();
        // Reset state
        chk("rst_out_valid", 32'(out_valid_l), 32'd0);
        chk("rst_out_data", 32'(out_data_l), 32'd0);
        chk("rst_out_last", 32'(out_last_l), 32'd0);
        chk("rst_err_trunc", 32'(err_trunc_l), 32'd0);
        chk("rst_in_ready", 32'(in_ready_l), 32'd1);
`ifdef STRUCT_DESER_STATS_EN
        chk("rst_stat_structs", stat_structs_l, 32'd0);
        chk("rst_stat_trunc", 32'(stat_trunc_l), 32'd0);
`endif
        rstn = 1'b1;
        tick();

        // Basic assembly, both slot orders
        out_ready = 1'b1;
        beat(8'hAB, 1'b0);
        chk("t1_valid_b1", 32'(out_valid_l), 32'd0);
        beat(8'hCD, 1'b0);
        chk("t1_valid_b2", 32'(out_valid_l), 32'd0);
        beat(8'hEF, 1'b1);
        chk("t1_valid", 32'(out_valid_l), 32'd1);
        chk("t1_data_lsb", 32'(out_data_l), 32'h0FCDAB);
        chk("t1_data_msb", 32'(out_data_m), 32'h0ABCDE);
        chk("t1_last", 32'(out_last_l), 32'd1);
        idle();
        tick();
        chk("t1_valid_drop", 32'(out_valid_l), 32'd0);

        // Backpressure: first struct held, next struct's early beats still land
        out_ready = 1'b0;
        beat(8'h10, 1'b0);
        beat(8'h11, 1'b0);
        beat(8'h12, 1'b1);
        chk("t2_valid_a", 32'(out_valid_l), 32'd1);
        beat(8'h13, 1'b0);
        chk("t2_ready_b5", 32'(in_ready_l), 32'd1);
        beat(8'h14, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h15;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_ready_stall", 32'(in_ready_l), 32'd0);
            chk("t2_hold_data", 32'(out_data_l), 32'h21110);
            chk("t2_hold_valid", 32'(out_valid_l), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t2_ready_release", 32'(in_ready_l), 32'd1);
        tick();
        chk("t2_b2b_valid", 32'(out_valid_l), 32'd1);
        chk("t2_b_data_lsb", 32'(out_data_l), 32'h51413);
        chk("t2_b_data_msb", 32'(out_data_m), 32'h13141);
        chk("t2_b_last", 32'(out_last_l), 32'd1);
        idle();
        tick();
        chk("t2_valid_drop", 32'(out_valid_l), 32'd0);

        // Truncation: frame ends on the second beat
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b1);
        chk("t3_err_pulse", 32'(err_trunc_l), 32'd1);
        chk("t3_no_output", 32'(out_valid_l), 32'd0);
        beat(8'h01, 1'b0);
        chk("t3_err_clear", 32'(err_trunc_l), 32'd0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        chk("t3_valid", 32'(out_valid_l), 32'd1);
        chk("t3_data_lsb", 32'(out_data_l), 32'h30201);
        chk("t3_data_msb", 32'(out_data_m), 32'h01020);
        chk("t3_last", 32'(out_last_l), 32'd0);
        chk("t3_err_once", 32'(err_trunc_l), 32'd0);
        idle();
        tick();
`ifdef STRUCT_DESER_STATS_EN
        chk("t3_stat_structs", stat_structs_l, 32'd4);
        chk("t3_stat_trunc", 32'(stat_trunc_l), 32'd1);
`endif

        // Full throughput: one struct every three cycles
        for (int k = 1; k <= 9; k++) begin
            beat(8'(8'h20 + k), (k % 3) == 0);
            chk("t4_valid", 32'(out_valid_l), 32'((k % 3) == 0));
            if ((k % 3) == 0) begin
                chk("t4_data_lsb", 32'(out_data_l), 32'(thr_l[k / 3 - 1]));
                chk("t4_data_msb", 32'(out_data_m), 32'(thr_m[k / 3 - 1]));
            end
        end
        idle();
        tick();
        chk("t4_valid_drop", 32'(out_valid_l), 32'd0);

        // Reset with a pending output and a partial struct
        out_ready = 1'b0;
        beat(8'hC1, 1'b0);
        beat(8'hC2, 1'b0);
        beat(8'hC3, 1'b1);
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b0);
        chk("t5_pending", 32'(out_valid_l), 32'd1);
        idle();
        rstn = 1'b0;
        tick();
        chk("t5_rst_valid", 32'(out_valid_l), 32'd0);
        chk("t5_rst_err", 32'(err_trunc_l), 32'd0);
        chk("t5_rst_ready", 32'(in_ready_l), 32'd1);
`ifdef STRUCT_DESER_STATS_EN
        chk("t5_rst_stat", stat_structs_l, 32'd0);
`endif
        rstn = 1'b1;
        out_ready = 1'b1;
        beat(8'h11, 1'b0);
        chk("t5_err_b1", 32'(err_trunc_l), 32'd0);
        beat(8'h22, 1'b0);
        chk("t5_err_b2", 32'(err_trunc_l), 32'd0);
        beat(8'h33, 1'b1);
        chk("t5_valid", 32'(out_valid_l), 32'd1);
        chk("t5_data_lsb", 32'(out_data_l), 32'h32211);
        chk("t5_data_msb", 32'(out_data_m), 32'h11223);
        chk("t5_err_b3", 32'(err_trunc_l), 32'd0);
        idle();
        tick();
`ifdef STRUCT_DESER_STATS_EN
        chk("t5_stat_structs", stat_structs_l, 32'd1);
        chk("t5_stat_trunc", 32'(stat_trunc_l), 32'd0);
`endif
        chk("t5_valid_drop", 32'(out_valid_l), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
